// File: rtl/stopwatch_display_scan.sv
// -----------------------------------------------------------------------------
// stopwatch_display_scan
//   Scans the stopwatch's 4-digit BCD time onto a shared 7-segment display.
//   A snapshot of Q is taken once per scan frame so all four digits of one
//   frame come from the same instant. Leading-zero blanking, illegal-digit
//   dash plus sticky ERR flag, and whole-display blink while paused.
//
// Ports
//   clk_in    : system clock
//   RESET_N   : asynchronous active-low reset
//   Q[16:1]   : BCD time {digit4, digit3, digit2, digit1}
//   PAUSED    : 1 = blink the display
//   BLANK_LZ  : 1 = blank digit4 when it is zero
//   AN[4:1]   : digit enables, at most one asserted
//   SEG[7:1]  : segments {g,f,e,d,c,b,a}
//   DP        : decimal point (lit on the digit3 slot only)
//   ERR       : sticky illegal-digit flag (always active-high)
// -----------------------------------------------------------------------------
module stopwatch_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int COMMON_ANODE = 1
) (
    input  logic        clk_in,
    input  logic        RESET_N,
    input  logic [16:1] Q,
    input  logic        PAUSED,
    input  logic        BLANK_LZ,
    output logic [4:1]  AN,
    output logic [7:1]  SEG,
    output logic        DP,
    output logic        ERR
);

    localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Polarity mask: outputs are XORed with this so internal logic is active-high.
    localparam logic POL = (COMMON_ANODE != 0);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [16:1]   r_snap;
    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_on;

    logic          w_tick;
    logic          w_frame;
    logic [1:0]    w_idx_nxt;
    logic [3:0]    w_dig;
    logic          w_illegal;
    logic          w_lz;
    logic [3:0]    w_an_ah;
    logic [6:0]    w_seg_ah;
    logic          w_dp_ah;
    logic [FW-1:0] w_fc_nxt;
    logic          w_blink_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b1000000;
        endcase
    endfunction

    assign w_tick    = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_idx_nxt = r_idx + 2'd1;
    assign w_frame   = w_tick && (r_idx == 2'd3);

    // Digit for the slot about to be shown. The idx0 slot starts the frame in
    // the same cycle the snapshot is loaded, so it reads Q directly.
    always_comb begin
        w_dig = 4'd0;
        case (w_idx_nxt)
            2'd0: w_dig = Q[4:1];
            2'd1: w_dig = r_snap[8:5];
            2'd2: w_dig = r_snap[12:9];
            2'd3: w_dig = r_snap[16:13];
            default: w_dig = 4'd0;
        endcase
    end

    assign w_illegal = (w_dig > 4'd9) || ((w_idx_nxt == 2'd1) && (w_dig > 4'd5));
    assign w_lz      = BLANK_LZ && (w_idx_nxt == 2'd3) && (w_dig == 4'd0);

    // Blink phase. Outputs use the post-update value so a phase change lands
    // cleanly on a frame boundary, and releasing PAUSED takes effect at the
    // very next slot update.
    always_comb begin
        w_fc_nxt    = r_frame_cnt;
        w_blink_nxt = r_blink_on;
        if (!PAUSED) begin
            w_fc_nxt    = '0;
            w_blink_nxt = 1'b1;
        end else if (w_frame) begin
            if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                w_fc_nxt    = '0;
                w_blink_nxt = ~r_blink_on;
            end else begin
                w_fc_nxt = r_frame_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        w_an_ah  = 4'b0001 << w_idx_nxt;
        w_seg_ah = w_illegal ? 7'b1000000 : seg7(w_dig);
        w_dp_ah  = (w_idx_nxt == 2'd2);
        if (w_lz) begin
            w_an_ah  = 4'b0000;
            w_seg_ah = 7'b0000000;
            w_dp_ah  = 1'b0;
        end
        if (PAUSED && !w_blink_nxt)
            w_an_ah = 4'b0000;
    end

    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc     <= '0;
            r_idx       <= 2'd3;
            r_snap      <= '0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
            AN          <= {4{POL}};
            SEG         <= {7{POL}};
            DP          <= POL;
            ERR         <= 1'b0;
        end else begin
            r_presc     <= w_tick ? '0 : r_presc + PW'(1);
            r_frame_cnt <= w_fc_nxt;
            r_blink_on  <= w_blink_nxt;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                AN    <= w_an_ah ^ {4{POL}};
                SEG   <= w_seg_ah ^ {7{POL}};
                DP    <= w_dp_ah ^ POL;
                if (w_illegal)
                    ERR <= 1'b1;
            end
            if (w_frame)
                r_snap <= Q;
        end
    end

endmodule
